// File: rtl/writeback_arbiter.sv
// Purpose: merge ALU results and load returns into the single register-file write port, with operand bypass.
// Latency: one cycle from accepted result to rf_write_enable; operand bypass and load_hazard are combinational.
// Backpressure: mem_ready drops while a load is parked; alu_ready drops only when a starved parked load pre-empts the ALU.
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   alu_valid/ready/rd/value         ALU result handshake
//   mem_valid/ready/rd/value         load return handshake
//   rf_write_enable/address/value    registered register-file write port
//   rs1, rs2, rf_read1, rf_read2     decode-stage read addresses and raw read data
//   operand1, operand2               read data with write-port bypass applied
//   load_hazard                      a source register matches the parked load
module writeback_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_value,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_value,
   output logic            rf_write_enable,
   output logic [4:0]      rf_address_write,
   output logic [XLEN-1:0] rf_value_write,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [XLEN-1:0] rf_read1,
   input  logic [XLEN-1:0] rf_read2,
   output logic [XLEN-1:0] operand1,
   output logic [XLEN-1:0] operand2,
   output logic            load_hazard
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   // One-entry park buffer for a load that lost arbitration
   logic            hold_valid, hold_valid_nxt;
   logic [4:0]      hold_rd, hold_rd_nxt;
   logic [XLEN-1:0] hold_value, hold_value_nxt;
   logic [CW-1:0]   starve_cnt, starve_cnt_nxt;

   logic            wr_en_nxt;
   logic [4:0]      wr_addr_nxt;
   logic [XLEN-1:0] wr_val_nxt;

   logic            starved;
   logic            mem_fire;

   assign starved   = hold_valid && (starve_cnt == LIMIT_C);
   assign alu_ready = !reset && !starved;
   assign mem_ready = !reset && !hold_valid;
   assign mem_fire  = mem_valid && mem_ready;

   always_comb begin
      hold_valid_nxt = hold_valid;
      hold_rd_nxt    = hold_rd;
      hold_value_nxt = hold_value;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = rf_address_write;
      wr_val_nxt     = rf_value_write;

      if (starved) begin
         // Parked load has waited long enough; ALU is stalled this cycle
         wr_en_nxt      = 1'b1;
         wr_addr_nxt    = hold_rd;
         wr_val_nxt     = hold_value;
         hold_valid_nxt = 1'b0;
      end else if (alu_valid) begin
         if (alu_rd != 5'd0) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = alu_rd;
            wr_val_nxt  = alu_value;
            // Parked load is older than this ALU result, so it is superseded
            if (hold_valid && (hold_rd == alu_rd))
               hold_valid_nxt = 1'b0;
         end
         // A load only fires when the hold is empty; it parks unless it is
         // x0 or already superseded by the same-cycle ALU write
         if (mem_fire && (mem_rd != 5'd0) && (mem_rd != alu_rd)) begin
            hold_valid_nxt = 1'b1;
            hold_rd_nxt    = mem_rd;
            hold_value_nxt = mem_value;
         end
      end else if (hold_valid) begin
         wr_en_nxt      = 1'b1;
         wr_addr_nxt    = hold_rd;
         wr_val_nxt     = hold_value;
         hold_valid_nxt = 1'b0;
      end else if (mem_fire && (mem_rd != 5'd0)) begin
         wr_en_nxt   = 1'b1;
         wr_addr_nxt = mem_rd;
         wr_val_nxt  = mem_value;
      end
   end

   // Count only cycles where an already-parked entry survives unwritten;
   // a freshly parked entry starts from zero
   always_comb begin
      starve_cnt_nxt = '0;
      if (hold_valid && hold_valid_nxt)
         starve_cnt_nxt = (starve_cnt == LIMIT_C) ? starve_cnt : starve_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_valid       <= 1'b0;
         hold_rd          <= '0;
         hold_value       <= '0;
         starve_cnt       <= '0;
         rf_write_enable  <= 1'b0;
         rf_address_write <= '0;
         rf_value_write   <= '0;
      end else begin
         hold_valid       <= hold_valid_nxt;
         hold_rd          <= hold_rd_nxt;
         hold_value       <= hold_value_nxt;
         starve_cnt       <= starve_cnt_nxt;
         rf_write_enable  <= wr_en_nxt;
         rf_address_write <= wr_addr_nxt;
         rf_value_write   <= wr_val_nxt;
      end
   end

   // Bypass the write that commits on the next edge so decode sees it now
   assign operand1 = ((rs1 != 5'd0) && rf_write_enable && (rf_address_write == rs1))
                     ? rf_value_write : rf_read1;
   assign operand2 = ((rs2 != 5'd0) && rf_write_enable && (rf_address_write == rs2))
                     ? rf_value_write : rf_read2;

   assign load_hazard = hold_valid && (((rs1 != 5'd0) && (rs1 == hold_rd)) ||
                                       ((rs2 != 5'd0) && (rs2 == hold_rd)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Purpose: directed self-checking bench for writeback_arbiter.
// Latency: registered outputs checked 1 time unit after each rising edge.
// Backpressure: ready outputs checked combinationally before each edge.
module tb_writeback_arbiter;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            alu_valid, alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_value;
   logic            mem_valid, mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_value;
   logic            rf_write_enable;
   logic [4:0]      rf_address_write;
   logic [XLEN-1:0] rf_value_write;
   logic [4:0]      rs1, rs2;
   logic [XLEN-1:0] rf_read1, rf_read2;
   logic [XLEN-1:0] operand1, operand2;
   logic            load_hazard;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   writeback_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_value(alu_value),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_value(mem_value),
      .rf_write_enable(rf_write_enable), .rf_address_write(rf_address_write),
      .rf_value_write(rf_value_write),
      .rs1(rs1), .rs2(rs2), .rf_read1(rf_read1), .rf_read2(rf_read2),
      .operand1(operand1), .operand2(operand2), .load_hazard(load_hazard)
   );

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_value = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_value = '0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] v);
      alu_valid = 1'b1; alu_rd = rd; alu_value = v;
   endtask

   task automatic drive_mem(input logic [4:0] rd, input logic [XLEN-1:0] v);
      mem_valid = 1'b1; mem_rd = rd; mem_value = v;
   endtask

   task automatic test_reset();
      idle(); rs1 = '0; rs2 = '0; rf_read1 = '0; rf_read2 = '0;
      reset = 1'b1;
      tick(); tick();
      vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready got %0b want 0", alu_ready); end
      vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ready got %0b want 0", mem_ready); end
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we got %0b want 0", rf_write_enable); end
      vectors++; if (rf_address_write !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", rf_address_write); end
      vectors++; if (rf_value_write !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", rf_value_write); end
      vectors++; if (load_hazard !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %0b want 0", load_hazard); end
      reset = 1'b0;
      #1;
      vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_mem_ready got %0b want 1", mem_ready); end
      tick();
   endtask

   task automatic test_alu_only();
      drive_alu(5'd3, 32'h11);
      #1;
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_only_ready got %0b want 1", alu_ready); end
      tick(); idle();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd3, 32'h11})
         begin miscompares++; $display("FAIL alu_only_write got we=%0b a=%0d d=%h want we=1 a=3 d=11", rf_write_enable, rf_address_write, rf_value_write); end
      tick();
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL alu_only_idle_we got %0b want 0", rf_write_enable); end
   endtask

   task automatic test_collision();
      drive_alu(5'd4, 32'hAA); drive_mem(5'd5, 32'hBB);
      #1;
      vectors++; if ({alu_ready, mem_ready} !== 2'b11) begin miscompares++; $display("FAIL coll_readies got %b want 11", {alu_ready, mem_ready}); end
      tick(); idle();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd4, 32'hAA})
         begin miscompares++; $display("FAIL coll_first got we=%0b a=%0d d=%h want we=1 a=4 d=aa", rf_write_enable, rf_address_write, rf_value_write); end
      vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL coll_mem_ready got %0b want 0", mem_ready); end
      tick();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd5, 32'hBB})
         begin miscompares++; $display("FAIL coll_second got we=%0b a=%0d d=%h want we=1 a=5 d=bb", rf_write_enable, rf_address_write, rf_value_write); end
      vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL coll_mem_ready_after got %0b want 1", mem_ready); end
      tick();
   endtask

   task automatic test_starvation();
      drive_alu(5'd1, 32'h100); drive_mem(5'd6, 32'h66);
      tick(); mem_valid = 1'b0;
      vectors++; if ({rf_write_enable, rf_address_write} !== {1'b1, 5'd1}) begin miscompares++; $display("FAIL starve_park got we=%0b a=%0d want we=1 a=1", rf_write_enable, rf_address_write); end
      for (int k = 1; k <= 4; k++) begin
         drive_alu(5'(10 + k), 32'(k));
         #1;
         vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL starve_alu_ready_%0d got %0b want 1", k, alu_ready); end
         tick();
         vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'(10 + k), 32'(k)})
            begin miscompares++; $display("FAIL starve_alu_write_%0d got we=%0b a=%0d d=%h", k, rf_write_enable, rf_address_write, rf_value_write); end
      end
      drive_alu(5'd20, 32'h20);
      #1;
      vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL starve_preempt_ready got %0b want 0", alu_ready); end
      tick();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd6, 32'h66})
         begin miscompares++; $display("FAIL starve_load_write got we=%0b a=%0d d=%h want we=1 a=6 d=66", rf_write_enable, rf_address_write, rf_value_write); end
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL starve_release_ready got %0b want 1", alu_ready); end
      tick(); idle();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd20, 32'h20})
         begin miscompares++; $display("FAIL starve_held_alu got we=%0b a=%0d d=%h want we=1 a=20 d=20", rf_write_enable, rf_address_write, rf_value_write); end
      tick();
   endtask

   task automatic test_supersede();
      drive_alu(5'd8, 32'h80); drive_mem(5'd7, 32'h1);
      tick(); mem_valid = 1'b0;
      drive_alu(5'd7, 32'h2);
      tick(); idle();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd7, 32'h2})
         begin miscompares++; $display("FAIL supersede_write got we=%0b a=%0d d=%h want we=1 a=7 d=2", rf_write_enable, rf_address_write, rf_value_write); end
      rs1 = 5'd7;
      #1;
      vectors++; if ({mem_ready, load_hazard} !== 2'b10) begin miscompares++; $display("FAIL supersede_hold_cleared got ready,hazard=%b want 10", {mem_ready, load_hazard}); end
      tick(); rs1 = '0;
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL supersede_no_stale got we=%0b want 0", rf_write_enable); end
      // Same-cycle load to the ALU's rd is dropped rather than parked
      drive_alu(5'd17, 32'hA); drive_mem(5'd17, 32'hB);
      tick(); idle();
      vectors++; if ({mem_ready, rf_value_write} !== {1'b1, 32'hA}) begin miscompares++; $display("FAIL same_rd_drop got ready=%0b d=%h want 1 a", mem_ready, rf_value_write); end
      tick();
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL same_rd_no_write got we=%0b want 0", rf_write_enable); end
   endtask

   task automatic test_x0_bypass();
      drive_alu(5'd0, 32'h99);
      #1;
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready got %0b want 1", alu_ready); end
      tick(); idle();
      vectors++; if (rf_write_enable !== 1'b0) begin miscompares++; $display("FAIL x0_alu_we got %0b want 0", rf_write_enable); end
      drive_mem(5'd0, 32'h77);
      tick(); idle();
      vectors++; if ({rf_write_enable, mem_ready} !== 2'b01) begin miscompares++; $display("FAIL x0_mem got we,ready=%b want 01", {rf_write_enable, mem_ready}); end
      drive_alu(5'd9, 32'h55);
      tick(); idle();
      rs1 = 5'd9; rs2 = 5'd3; rf_read1 = 32'hDEAD; rf_read2 = 32'hBEEF;
      #1;
      vectors++; if (operand1 !== 32'h55) begin miscompares++; $display("FAIL bypass_op1 got %h want 55", operand1); end
      vectors++; if (operand2 !== 32'hBEEF) begin miscompares++; $display("FAIL bypass_op2_raw got %h want beef", operand2); end
      tick();
      vectors++; if (operand1 !== 32'hDEAD) begin miscompares++; $display("FAIL bypass_expired got %h want dead", operand1); end
      rs1 = '0; rs2 = '0;
      drive_alu(5'd13, 32'h13); drive_mem(5'd12, 32'h12);
      tick(); idle();
      rs2 = 5'd12;
      #1;
      vectors++; if (load_hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_rs2 got %0b want 1", load_hazard); end
      rs1 = 5'd12; rs2 = 5'd0;
      #1;
      vectors++; if (load_hazard !== 1'b1) begin miscompares++; $display("FAIL hazard_rs1 got %0b want 1", load_hazard); end
      rs1 = 5'd11;
      #1;
      vectors++; if (load_hazard !== 1'b0) begin miscompares++; $display("FAIL hazard_miss got %0b want 0", load_hazard); end
      rs1 = '0;
      tick();
      vectors++; if ({rf_write_enable, rf_address_write, rf_value_write} !== {1'b1, 5'd12, 32'h12})
         begin miscompares++; $display("FAIL hazard_drain got we=%0b a=%0d d=%h want we=1 a=12 d=12", rf_write_enable, rf_address_write, rf_value_write); end
      tick();
   endtask

   task automatic test_reset_midop();
      drive_alu(5'd14, 32'h14); drive_mem(5'd15, 32'h15);
      tick(); idle();
      reset = 1'b1;
      #1;
      vectors++; if ({alu_ready, mem_ready} !== 2'b00) begin miscompares++; $display("FAIL midreset_readies got %b want 00", {alu_ready, mem_ready}); end
      tick();
      rs1 = 5'd15;
      #1;
      vectors++; if ({rf_write_enable, load_hazard} !== 2'b00) begin miscompares++; $display("FAIL midreset_state got we,hazard=%b want 00", {rf_write_enable, load_hazard}); end
      reset = 1'b0;
      tick(); rs1 = '0;
      vectors++; if ({rf_write_enable, mem_ready} !== 2'b01) begin miscompares++; $display("FAIL midreset_after got we,ready=%b want 01", {rf_write_enable, mem_ready}); end
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_collision();
      test_starvation();
      test_supersede();
      test_x0_bypass();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
